io_handshake_controller: RTL and testbench

//  Registered I/O controller between the CPU decode stage and the board switches, button and LEDs.
//  IN: stalls the CPU until a debounced confirm press/release, then returns the zero-extended switches.
//  OUT: latches a display value and sign flag. HLT: sticky halt.

---
 rtl/io_handshake_controller.sv | 155 +++++++++++++++
 tb/tb_io_handshake_controller.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_handshake_controller.sv
// CPU-side I/O controller: debounced IN handshake, latched OUT display, sticky HLT.
// Define OUT_SIGN_MAG_EN to show OUT values as sign + magnitude instead of raw bits.
//
// state          | meaning
// S_IDLE         | decode OUT/HLT immediately, IN starts a handshake
// S_WAIT_PRESS   | CPU stalled, counting stable confirm=1 cycles
// S_WAIT_RELEASE | CPU stalled, counting stable confirm=0 cycles
// S_DONE         | one-cycle in_done pulse, opcode ignored
// S_HALT         | sticky halt, left only through reset_n
module io_handshake_controller #(
    parameter int              DATA_W       = 32,
    parameter int              SW_W         = 18,
    parameter int              OP_W         = 6,
    parameter logic [OP_W-1:0] OP_IN        = 6'b011101,
    parameter logic [OP_W-1:0] OP_OUT       = 6'b100000,
    parameter logic [OP_W-1:0] OP_HLT       = 6'b011100,
    parameter int              DEBOUNCE_CYC = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [OP_W-1:0]   operation,
    input  logic [SW_W-1:0]   switches,
    input  logic              confirm,
    input  logic [DATA_W-1:0] io_ram_output,
    output logic [DATA_W-1:0] in_data,
    output logic              in_done,
    output logic              stall,
    output logic [DATA_W-1:0] display,
    output logic              in_led,
    output logic              out_led,
    output logic              neg_led,
    output logic              halted
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_PRESS,
        S_WAIT_RELEASE,
        S_DONE,
        S_HALT
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              cnt_hit;
    logic [DATA_W-1:0] in_data_q;
    logic [DATA_W-1:0] display_q;
    logic [DATA_W-1:0] disp_d;
    logic              neg_d;
    logic              in_done_q;
    logic              in_led_q;
    logic              out_led_q;
    logic              neg_led_q;
    logic              halted_q;

    // Saturating increment; a hit means this edge completes the stable run.
    assign cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign cnt_hit = (cnt_d == CNT_MAX);

`ifdef OUT_SIGN_MAG_EN
    assign neg_d  = io_ram_output[DATA_W-1];
    assign disp_d = neg_d ? (~io_ram_output + 1'b1) : io_ram_output;
`else
    assign neg_d  = 1'b0;
    assign disp_d = io_ram_output;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            in_data_q <= '0;
            display_q <= '0;
            in_done_q <= 1'b0;
            in_led_q  <= 1'b0;
            out_led_q <= 1'b0;
            neg_led_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    in_done_q <= 1'b0;
                    if (operation == OP_IN) begin
                        state_q  <= S_WAIT_PRESS;
                        in_led_q <= 1'b1;
                        cnt_q    <= '0;
                    end else if (operation == OP_OUT) begin
                        display_q <= disp_d;
                        neg_led_q <= neg_d;
                        out_led_q <= 1'b1;
                    end else if (operation == OP_HLT) begin
                        state_q   <= S_HALT;
                        halted_q  <= 1'b1;
                        in_led_q  <= 1'b1;
                        out_led_q <= 1'b1;
                        neg_led_q <= 1'b1;
                        display_q <= '0;
                    end
                end
                S_WAIT_PRESS: begin
                    if (!confirm) begin
                        cnt_q <= '0;
                    end else if (cnt_hit) begin
                        cnt_q     <= '0;
                        in_data_q <= DATA_W'(switches);
                        state_q   <= S_WAIT_RELEASE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_WAIT_RELEASE: begin
                    if (confirm) begin
                        cnt_q <= '0;
                    end else if (cnt_hit) begin
                        cnt_q     <= '0;
                        in_done_q <= 1'b1;
                        in_led_q  <= 1'b0;
                        state_q   <= S_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_DONE: begin
                    in_done_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // An IN in decode must hold the CPU in the same cycle it is seen.
    assign stall = reset_n & ((state_q == S_IDLE && operation == OP_IN) ||
                              state_q == S_WAIT_PRESS ||
                              state_q == S_WAIT_RELEASE ||
                              state_q == S_HALT);

    assign in_data = in_data_q;
    assign in_done = in_done_q;
    assign display = display_q;
    assign in_led  = in_led_q;
    assign out_led = out_led_q;
    assign neg_led = neg_led_q;
    assign halted  = halted_q;

endmodule

// File: tb/tb_io_handshake_controller.sv
// Directed and randomized checks of io_handshake_controller against a transaction-level model.
// Expectations for OUT follow OUT_SIGN_MAG_EN the same way the design build does.
module tb_io_handshake_controller;

    localparam int DATA_W = 32;
    localparam int SW_W   = 18;
    localparam int OP_W   = 6;
    localparam int DEB    = 4;
    localparam logic [OP_W-1:0] OP_IN  = 6'b011101;
    localparam logic [OP_W-1:0] OP_OUT = 6'b100000;
    localparam logic [OP_W-1:0] OP_HLT = 6'b011100;
    localparam logic [OP_W-1:0] OP_NOP = 6'b000000;

    logic              clock;
    logic              reset_n;
    logic [OP_W-1:0]   operation;
    logic [SW_W-1:0]   switches;
    logic              confirm;
    logic [DATA_W-1:0] io_ram_output;
    logic [DATA_W-1:0] in_data;
    logic              in_done;
    logic              stall;
    logic [DATA_W-1:0] display;
    logic              in_led;
    logic              out_led;
    logic              neg_led;
    logic              halted;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_disp;
    logic              exp_neg;
    logic              exp_oled;
    logic [DATA_W-1:0] exp_in;
    bit                pat [0:31];
    int                plen;

    io_handshake_controller dut (
        .clock(clock), .reset_n(reset_n), .operation(operation), .switches(switches),
        .confirm(confirm), .io_ram_output(io_ram_output), .in_data(in_data),
        .in_done(in_done), .stall(stall), .display(display), .in_led(in_led),
        .out_led(out_led), .neg_led(neg_led), .halted(halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference OUT rule: {neg, shown value}
    function automatic logic [DATA_W:0] out_rule(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] mag;
`ifdef OUT_SIGN_MAG_EN
        mag = x[DATA_W-1] ? (DATA_W'(0) - x) : x;
        return {x[DATA_W-1], mag};
`else
        mag = x;
        return {1'b0, mag};
`endif
    endfunction

    function automatic logic [OP_W-1:0] other_op();
        logic [OP_W-1:0] v;
        v = OP_W'($urandom);
        if (v == OP_IN || v == OP_OUT || v == OP_HLT) v = 6'b000001;
        return v;
    endfunction

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_display"}, 64'(display), 64'(exp_disp));
        chk({tag, "_neg_led"}, 64'(neg_led), 64'(exp_neg));
        chk({tag, "_out_led"}, 64'(out_led), 64'(exp_oled));
        chk({tag, "_in_data"}, 64'(in_data), 64'(exp_in));
        chk({tag, "_stall"}, 64'(stall), 64'(0));
    endtask

    task automatic do_op(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] io);
        logic [DATA_W:0] r;
        operation     = op;
        io_ram_output = io;
        tick();
        if (op == OP_OUT) begin
            r        = out_rule(io);
            exp_disp = r[DATA_W-1:0];
            exp_neg  = r[DATA_W];
            exp_oled = 1'b1;
        end
        chk_idle_outs(op == OP_OUT ? "out" : "hold");
    endtask

    task automatic gen_pat();
        int n;
        plen = 0;
        n = $urandom_range(0, 8);
        for (int i = 0; i < n; i++) begin pat[plen] = 1'($urandom); plen++; end
        for (int i = 0; i < DEB; i++) begin pat[plen] = 1'b1; plen++; end
        n = $urandom_range(0, 8);
        for (int i = 0; i < n; i++) begin pat[plen] = 1'($urandom); plen++; end
        for (int i = 0; i < DEB; i++) begin pat[plen] = 1'b0; plen++; end
    endtask

    // One IN transaction driven from pat[]; the model locates the accepted press and release by run length.
    task automatic run_in(input bit rand_sw, input logic [SW_W-1:0] sw_fix);
        logic [SW_W-1:0]   swv [0:31];
        logic [DATA_W-1:0] new_in;
        int press_idx, rel_idx, run;
        press_idx = -1;
        rel_idx   = -1;
        run       = 0;
        for (int i = 0; i < plen; i++) begin
            swv[i] = rand_sw ? SW_W'($urandom) : sw_fix;
            if (press_idx < 0) begin
                run = pat[i] ? run + 1 : 0;
                if (run == DEB) begin press_idx = i; run = 0; end
            end else if (rel_idx < 0) begin
                run = !pat[i] ? run + 1 : 0;
                if (run == DEB) rel_idx = i;
            end
        end
        new_in = DATA_W'(swv[press_idx]);

        operation = OP_IN;
        confirm   = 1'b0;
        #1;
        chk("in_stall_comb", 64'(stall), 64'(1));
        tick();
        chk("in_wait_led", 64'(in_led), 64'(1));
        for (int i = 0; i <= rel_idx; i++) begin
            confirm  = pat[i];
            switches = swv[i];
            tick();
            if (i < rel_idx) begin
                chk("in_wait_stall", 64'(stall), 64'(1));
                chk("in_wait_done", 64'(in_done), 64'(0));
                chk("in_wait_data", 64'(in_data), 64'(i >= press_idx ? new_in : exp_in));
            end else begin
                chk("in_done_pulse", 64'(in_done), 64'(1));
                chk("in_done_stall", 64'(stall), 64'(0));
                chk("in_done_led", 64'(in_led), 64'(0));
                chk("in_done_data", 64'(in_data), 64'(new_in));
            end
        end
        exp_in    = new_in;
        operation = OP_NOP;
        confirm   = 1'b0;
        tick();
        chk("in_after_done", 64'(in_done), 64'(0));
        chk_idle_outs("in_after");
    endtask

    initial begin
        reset_n       = 1'b0;
        operation     = OP_NOP;
        switches      = '0;
        confirm       = 1'b0;
        io_ram_output = '0;
        exp_disp = '0; exp_neg = 1'b0; exp_oled = 1'b0; exp_in = '0;
        #2;
        chk_idle_outs("reset");
        chk("reset_halted", 64'(halted), 64'(0));
        chk("reset_in_led", 64'(in_led), 64'(0));
        tick();
        reset_n = 1'b1;
        tick();

        // Bouncy press 1-1-0 then steady press and release.
        plen = 11;
        for (int i = 0; i < 11; i++) pat[i] = (i < 2 || (i >= 3 && i < 7)) ? 1'b1 : 1'b0;
        run_in(1'b0, 18'h2A5F3);
        chk("dir_in_data", 64'(in_data), 64'(32'h0002A5F3));

        do_op(OP_OUT, 32'hFFFFFFF6);
        do_op(OP_NOP, 32'h00000123);
        do_op(6'b000111, 32'h00000456);
        do_op(OP_OUT, 32'h80000000);
        do_op(OP_OUT, 32'h7FFFFFFF);
        do_op(OP_OUT, 32'h00000000);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 8; k++) begin
                logic [DATA_W-1:0] v;
                case ($urandom_range(0, 3))
                    0:       v = 32'h80000000;
                    1:       v = 32'hFFFFFFFF;
                    default: v = $urandom;
                endcase
                do_op($urandom_range(0, 1) ? OP_OUT : other_op(), v);
            end
            gen_pat();
            run_in(1'b1, '0);
        end

        // Async reset in the middle of a press wait.
        do_op(OP_OUT, 32'h00012345);
        operation = OP_IN;
        tick();
        confirm = 1'b1;
        tick();
        tick();
        chk("mid_wait_stall", 64'(stall), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        exp_disp = '0; exp_neg = 1'b0; exp_oled = 1'b0; exp_in = '0;
        chk_idle_outs("mid_reset");
        chk("mid_reset_in_led", 64'(in_led), 64'(0));
        chk("mid_reset_halted", 64'(halted), 64'(0));
        operation = OP_NOP;
        confirm   = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_reset_idle_stall", 64'(stall), 64'(0));
        chk("post_reset_idle_led", 64'(in_led), 64'(0));

        do_op(OP_OUT, 32'hFFFFFF00);
        operation = OP_HLT;
        tick();
        for (int k = 0; k < 12; k++) begin
            chk("halt_halted", 64'(halted), 64'(1));
            chk("halt_leds", 64'({in_led, out_led, neg_led}), 64'(3'b111));
            chk("halt_display", 64'(display), 64'(0));
            chk("halt_stall", 64'(stall), 64'(1));
            chk("halt_in_done", 64'(in_done), 64'(0));
            chk("halt_in_data", 64'(in_data), 64'(exp_in));
            case ($urandom_range(0, 2))
                0:       operation = OP_IN;
                1:       operation = OP_OUT;
                default: operation = other_op();
            endcase
            confirm       = 1'($urandom);
            switches      = SW_W'($urandom);
            io_ram_output = $urandom;
            tick();
        end

        operation = OP_IN;
        reset_n   = 1'b0;
        #1;
        exp_disp = '0; exp_neg = 1'b0; exp_oled = 1'b0; exp_in = '0;
        chk_idle_outs("final_reset");
        chk("final_reset_halted", 64'(halted), 64'(0));
        chk("final_reset_in_led", 64'(in_led), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
